// File: rtl/req_gnt_rr_arbiter.sv
// rtl/req_gnt_rr_arbiter.sv - round-robin req/gnt arbiter with hold timeout and post-grant gap
// Optional SVA checks compiled when REQ_GNT_RR_ARBITER_ASSERT_EN is defined.
module req_gnt_rr_arbiter #(
  parameter int N_CH       = 4,
  parameter int MAX_HOLD   = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_CH-1:0]         req,
  input  logic                    err_clr,
  output logic [N_CH-1:0]         gnt,
  output logic [$clog2(N_CH)-1:0] gnt_id,
  output logic                    busy,
  output logic [N_CH-1:0]         timeout_err
);

  localparam int IW = $clog2(N_CH);
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   ptr, ptr_nx, id_nx, pick_idx, cand;
  logic [HW-1:0]   hold_cnt, hold_nx;
  logic [GW-1:0]   gap_cnt, gap_nx;
  logic [N_CH-1:0] gnt_nx, err_set;
  logic            pick_ok, grant_end, revoke;
  int              j;

  // Rotating priority search starting at ptr
  always_comb begin
    pick_ok  = 1'b0;
    pick_idx = '0;
    cand     = '0;
    j        = 0;
    for (int i = 0; i < N_CH; i++) begin
      j = int'(ptr) + i;
      if (j >= N_CH) j = j - N_CH;
      cand = IW'(j);
      if (!pick_ok && req[cand]) begin
        pick_ok  = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    ptr_nx    = ptr;
    hold_nx   = hold_cnt;
    gap_nx    = gap_cnt;
    gnt_nx    = gnt;
    id_nx     = gnt_id;
    err_set   = '0;
    revoke    = 1'b0;
    grant_end = 1'b0;
    case (state)
      IDLE: begin
        if (pick_ok) begin
          gnt_nx   = N_CH'(1) << pick_idx;
          id_nx    = pick_idx;
          hold_nx  = HW'(1);
          state_nx = GRANT;
        end
      end
      GRANT: begin
        revoke    = req[gnt_id] && (MAX_HOLD != 0) && (hold_cnt == HW'(MAX_HOLD));
        grant_end = !req[gnt_id] || revoke;
        if (grant_end) begin
          gnt_nx  = '0;
          id_nx   = '0;
          gap_nx  = '0;
          ptr_nx  = (gnt_id == IW'(N_CH - 1)) ? '0 : gnt_id + 1'b1;
          if (revoke) err_set[gnt_id] = 1'b1;
          state_nx = (GAP_CYCLES == 0) ? IDLE : GAP;
        end else if (hold_cnt != '1) begin
          hold_nx = hold_cnt + 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt == GW'(GAP_CYCLES - 1)) state_nx = IDLE;
        else gap_nx = gap_cnt + 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      ptr         <= '0;
      hold_cnt    <= '0;
      gap_cnt     <= '0;
      gnt         <= '0;
      gnt_id      <= '0;
      timeout_err <= '0;
    end else begin
      state       <= state_nx;
      ptr         <= ptr_nx;
      hold_cnt    <= hold_nx;
      gap_cnt     <= gap_nx;
      gnt         <= gnt_nx;
      gnt_id      <= id_nx;
      // A timeout set in the same cycle as err_clr survives the clear
      timeout_err <= (timeout_err & ~{N_CH{err_clr}}) | err_set;
    end
  end

  assign busy = (state != IDLE);

`ifdef REQ_GNT_RR_ARBITER_ASSERT_EN
  a_onehot0: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(gnt))
    else $display("@%0t ns onehot0 failed", $time);

  if (GAP_CYCLES > 0) begin : g_gap_chk
    a_gap: assert property (@(posedge clk) disable iff (!reset_n)
      $fell(|gnt) |-> !(|gnt) [*GAP_CYCLES])
      else $display("@%0t ns gap failed", $time);
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch_chk
    a_req_before_gnt: assert property (@(posedge clk) disable iff (!reset_n)
      (gnt[i] && !$past(gnt[i])) |-> $past(req[i]))
      else $display("@%0t ns req_before_gnt failed", $time);
    if (MAX_HOLD > 0) begin : g_hold_chk
      a_max_hold: assert property (@(posedge clk) disable iff (!reset_n)
        $rose(gnt[i]) |-> ##[1:MAX_HOLD] !gnt[i])
        else $display("@%0t ns max_hold failed", $time);
    end
  end
`else
`endif

endmodule

// File: tb/tb_req_gnt_rr_arbiter.sv
// tb/tb_req_gnt_rr_arbiter.sv - self-checking bench for req_gnt_rr_arbiter
// Cycle model of the grant rules plus directed literal checks.
module tb_req_gnt_rr_arbiter;
  localparam int N  = 4;
  localparam int MH = 8;
  localparam int GC = 1;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         err_clr = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] gnt, timeout_err;
  logic [1:0]   gnt_id;
  logic         busy;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  req_gnt_rr_arbiter #(.N_CH(N), .MAX_HOLD(MH), .GAP_CYCLES(GC)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .err_clr(err_clr),
    .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: who owns the resource, how long, how many quiet cycles remain
  int           m_owner = -1;
  int           m_held  = 0;
  int           m_quiet = 0;
  int           m_next  = 0;
  logic [N-1:0] m_err   = '0;
  logic [N-1:0] m_set;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_owner = -1; m_held = 0; m_quiet = 0; m_next = 0; m_err = '0;
    end else begin
      m_set = '0;
      if (m_owner >= 0) begin
        if (!req[m_owner] || m_held == MH) begin
          if (req[m_owner]) m_set[m_owner] = 1'b1;
          m_next  = (m_owner + 1) % N;
          m_owner = -1;
          m_quiet = GC;
        end else begin
          m_held++;
        end
      end else if (m_quiet > 0) begin
        m_quiet--;
      end else if (req != '0) begin
        for (int i = 0; i < N; i++)
          if (m_owner < 0 && req[(m_next + i) % N]) begin
            m_owner = (m_next + i) % N;
            m_held  = 1;
          end
      end
      m_err = (err_clr ? '0 : m_err) | m_set;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_gnt",  gnt,         (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      check("m_id",   gnt_id,      (m_owner >= 0) ? m_owner : 0);
      check("m_busy", busy,        (m_owner >= 0 || m_quiet > 0) ? 1 : 0);
      check("m_err",  timeout_err, m_err);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_gnt(input string nm);
    int c = 0;
    while (gnt == '0 && c < 100) begin step(1); c++; end
    check(nm, (gnt != '0), 1);
  endtask

  task automatic wait_idle(input string nm);
    int c = 0;
    while (busy && c < 100) begin step(1); c++; end
    check(nm, busy, 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
  endtask

  initial begin
    int n, idle;
    step(2);
    check("rst_gnt", gnt, 0);
    check("rst_id", gnt_id, 0);
    check("rst_busy", busy, 0);
    check("rst_err", timeout_err, 0);
    reset_n = 1'b1;
    cmp_en  = 1'b1;

    // Single pulse request
    req = 4'b0001;
    step(1);
    check("t1_gnt_hi", gnt, 4'b0001);
    req = 4'b0000;
    step(1);
    check("t1_gnt_lo", gnt, 4'b0000);
    step(1);
    check("t1_busy_lo", busy, 0);

    // All requesting: rotation, one IDLE cycle between grants, revoke at MAX_HOLD
    do_reset();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_gnt("t2_wait");
      check("t2_order", gnt_id, g % N);
      n = 0;
      while (gnt != '0 && n < 50) begin step(1); n++; end
      check("t2_hold_len", n, MH);
      if (g < 4) begin
        idle = 0; n = 0;
        while (gnt == '0 && n < 50) begin
          if (!busy) idle++;
          step(1); n++;
        end
        check("t2_idle_cycles", idle, 1);
      end
    end
    req = 4'b0000;
    wait_idle("t2_idle");
    check("t2_err_all", timeout_err, 4'b1111);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check("t2_err_clr", timeout_err, 4'b0000);

    // Timeout revoke on ch2, then pointer moves to ch3
    do_reset();
    req = 4'b0100;
    wait_gnt("t3_wait");
    n = 0;
    while (gnt[2] && n < 50) begin step(1); n++; end
    check("t3_hold_len", n, MH);
    check("t3_err", timeout_err, 4'b0100);
    req = 4'b1100;
    wait_gnt("t3_wait2");
    check("t3_next_ch3", gnt_id, 3);
    req = 4'b0000;
    wait_idle("t3_idle");
    check("t3_err_sticky", timeout_err, 4'b0100);

    // err_clr coincident with a ch1 timeout
    req = 4'b0010;
    wait_gnt("t4_wait");
    step(MH - 1);
    check("t4_still_held", gnt, 4'b0010);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check("t4_err", timeout_err, 4'b0010);
    req = 4'b0000;
    wait_idle("t4_idle");

    // Reset mid-grant restarts the pointer at ch0
    do_reset();
    req = 4'b1000;
    wait_gnt("t5_wait");
    check("t5_ch3", gnt_id, 3);
    reset_n = 1'b0;
    req = 4'b1111;
    step(1);
    check("t5_rst_gnt", gnt, 4'b0000);
    check("t5_rst_err", timeout_err, 4'b0000);
    reset_n = 1'b1;
    wait_gnt("t5_wait2");
    check("t5_first_ch0", gnt_id, 0);
    req = 4'b0000;
    step(12);

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
